pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter register and instruction-fetch stage of the MIPS pipeline. Holds the architectural PC (word address, bits [31:2]), presents it to the next-PC logic and instruction memory, and accepts the computed next PC back each cycle. Captures fetched instructions into the IF/ID pipeline register with stall, flush/redirect and variable-latency memory handshaking.

## Interface
- RESET_PC, 30'h0C00 (byte 0x0000_3000), word address loaded on reset
- NOP_INSTR, 32'h0000_0000, instruction word written into IF/ID on flush/bubble
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- Npc  input  [31:2]  next PC from next-PC logic, sampled when PC advances
- stall  input  1  hazard unit: hold PC and IF/ID
- flush  input  1  taken branch/jump: discard IF/ID, redirect PC to Npc
- imem_ready  input  1  memory accepted request; imem_rdata valid this cycle
- imem_rdata  input  [31:0]  instruction word
- PC  output  [31:2]  current fetch PC, to next-PC logic
- imem_req  output  1  fetch request
- imem_addr  output  [31:2]  fetch address (= PC)
- id_pc  output  [31:2]  PC of instruction in IF/ID
- id_instr  output  [31:0]  instruction in IF/ID
- id_valid  output  1  IF/ID holds a real instruction
- fetch_cnt  output  [31:0]  instructions delivered to IF/ID (see Configuration)
- bubble_cnt  output  [31:0]  cycles IF/ID loaded a bubble (see Configuration)

## Operation
- States: S_REQ (request outstanding), S_HOLD (instruction buffered, downstream stalled).
- imem_req = (state==S_REQ); imem_addr = PC. While imem_req && !imem_ready, PC/imem_addr must not change.
- "Accept" = imem_req && imem_ready.
- S_REQ, accept, !stall, !kill: IF/ID <= {PC, imem_rdata}, id_valid<=1; PC<=Npc; stay S_REQ.
- S_REQ, accept, stall: imem_rdata -> skid buffer; PC held; go S_HOLD.
- S_REQ, no accept, !stall: IF/ID loads bubble (NOP_INSTR, id_valid=0, id_pc unchanged).
- Any state, stall && !flush: IF/ID unchanged.
- S_HOLD, !stall: IF/ID <= {PC, skid}; PC<=Npc; go S_REQ. S_HOLD, stall: hold.
- flush (priority over stall): IF/ID <= bubble. If no request outstanding or request accepted this cycle: PC<=Npc, state S_REQ, skid discarded, returned data dropped. If request outstanding and not accepted: latch Npc into redirect register, set kill; PC held.
- kill set: on next accept, data dropped, PC<=redirect, kill cleared. A second flush while kill set overwrites redirect.
- Arithmetic: none; all PCs 30-bit word addresses, no wrap handling needed.

## Timing
- Reset (async): PC=RESET_PC, state=S_REQ, kill=0, redirect=0, id_pc=0, id_instr=NOP_INSTR, id_valid=0, counters=0; imem_req=1 in first cycle after reset release.
- Zero-wait memory (imem_ready tied 1): one instruction per cycle; instruction at PC appears in IF/ID the edge after it is requested (latency 1).
- N-wait memory: N bubbles into IF/ID per fetch.
- Stall and accept coinciding: no instruction lost or duplicated; skid adds 0 cycles after stall release.
- Reset mid-request: all state cleared immediately; memory must tolerate request abandonment.

## Configuration
- IF_PERF_CNT_EN defined: fetch_cnt increments on each IF/ID load with id_valid=1; bubble_cnt increments on each IF/ID bubble load caused by !imem_ready or flush (not by stall hold). Both wrap at 2^32.
- Undefined: counters not built; fetch_cnt and bubble_cnt tied to 0.

## Test plan
- Reset release, imem_ready=1, Npc=PC+1: id_pc = 0x0C00,0x0C01,0x0C02 on successive cycles, id_valid=1 from cycle 2.
- imem_ready low 2 cycles at PC=0x0C05: imem_addr stable 0x0C05, two bubbles (id_valid=0), then id_pc=0x0C05.
- stall high 3 cycles on accepted fetch of 0x0C08: IF/ID frozen, imem_req=0 in S_HOLD, after release id_pc=0x0C08 with correct instr, next 0x0C09.
- flush with Npc=0x0D00 during accepted cycle: next IF/ID bubble, then id_pc=0x0D00.
- flush with Npc=0x0E00 while fetch 0x0C10 pending 2 wait cycles: 0x0C10 data dropped, next request addr 0x0E00, id_pc=0x0E00.
- IF_PERF_CNT_EN: 10 fetches + 3 wait cycles + 1 flush -> fetch_cnt=10, bubble_cnt=4; async rst mid-run clears both to 0.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch stage.
// Holds the word-addressed PC, issues instruction-memory requests, and
// loads the IF/ID register. Stalls, flush/redirect and wait states are
// handled by a two-state FSM (S_REQ / S_HOLD). A one-entry skid buffer
// catches an instruction returned while downstream is stalled. A kill
// flag drops the response of a request that was flushed while still
// waiting.
// Optional feature macro: IF_PERF_CNT_EN builds the fetch and bubble
// counters. Without it, fetch_cnt and bubble_cnt are tied to zero.
module pc_fetch #(
  parameter logic [31:2] RESET_PC  = 30'h0C00,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] Npc,
  input  logic        stall,
  input  logic        flush,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:2] PC,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  output logic [31:2] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      state, state_nx;
  logic [31:2] pc_nx;
  logic        kill, kill_nx;
  logic [31:2] redirect, redirect_nx;
  logic [31:0] skid, skid_nx;
  logic        id_we;
  logic [31:2] id_pc_nx;
  logic [31:0] id_instr_nx;
  logic        id_valid_nx;
  logic        accept;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = PC;
  assign accept    = imem_req && imem_ready;

  // Next-state, next-PC and IF/ID load decisions; flush outranks stall.
  always_comb begin
    state_nx    = state;
    pc_nx       = PC;
    kill_nx     = kill;
    redirect_nx = redirect;
    skid_nx     = skid;
    id_we       = 1'b0;
    id_pc_nx    = id_pc;
    id_instr_nx = id_instr;
    id_valid_nx = id_valid;
    if (flush) begin
      id_we       = 1'b1;
      id_instr_nx = NOP_INSTR;
      id_valid_nx = 1'b0;
      if (state == S_HOLD || accept) begin
        // Nothing left in flight: redirect right away, drop skid/response.
        pc_nx    = Npc;
        state_nx = S_REQ;
        kill_nx  = 1'b0;
      end else begin
        // Request still waiting: PC must stay put, so remember the target.
        redirect_nx = Npc;
        kill_nx     = 1'b1;
      end
    end else if (state == S_REQ) begin
      if (accept && kill) begin
        // Response of a flushed request: discard it and jump to the target.
        pc_nx   = redirect;
        kill_nx = 1'b0;
        if (!stall) begin
          id_we       = 1'b1;
          id_instr_nx = NOP_INSTR;
          id_valid_nx = 1'b0;
        end
      end else if (accept && !stall) begin
        id_we       = 1'b1;
        id_pc_nx    = PC;
        id_instr_nx = imem_rdata;
        id_valid_nx = 1'b1;
        pc_nx       = Npc;
      end else if (accept) begin
        skid_nx  = imem_rdata;
        state_nx = S_HOLD;
      end else if (!stall) begin
        id_we       = 1'b1;
        id_instr_nx = NOP_INSTR;
        id_valid_nx = 1'b0;
      end
    end else if (!stall) begin
      // Skid drains the cycle stall drops, so no extra latency is added.
      id_we       = 1'b1;
      id_pc_nx    = PC;
      id_instr_nx = skid;
      id_valid_nx = 1'b1;
      pc_nx       = Npc;
      state_nx    = S_REQ;
    end
  end

  // Architectural and pipeline state, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      PC       <= RESET_PC;
      kill     <= 1'b0;
      redirect <= '0;
      skid     <= NOP_INSTR;
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      PC       <= pc_nx;
      kill     <= kill_nx;
      redirect <= redirect_nx;
      skid     <= skid_nx;
      if (id_we) begin
        id_pc    <= id_pc_nx;
        id_instr <= id_instr_nx;
        id_valid <= id_valid_nx;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Count real instruction loads and bubble loads into IF/ID; both wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (id_we) begin
      if (id_valid_nx) fetch_cnt  <= fetch_cnt + 32'd1;
      else             bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus a random stall/wait phase.
// Expected fetch PCs are queued when the bench drives an accepted request
// and are compared when IF/ID loads an instruction.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:2] npc;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:2] PC;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic [31:2] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  logic        npc_ovr_en = 1'b0;
  logic [31:2] npc_ovr = '0;

  int checks = 0;
  int fails  = 0;
  logic [31:2] exp_q[$];

  function automatic logic [31:0] instr_of(input logic [31:2] a);
    return {a, 2'b11} ^ 32'hDEAD_0000;
  endfunction

  // Next-PC logic stand-in and zero-latency instruction memory model.
  assign npc        = npc_ovr_en ? npc_ovr : PC + 30'd1;
  assign imem_rdata = instr_of(imem_addr);

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk(clk), .rst(rst), .Npc(npc), .stall(stall), .flush(flush),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC(PC),
    .imem_req(imem_req), .imem_addr(imem_addr), .id_pc(id_pc),
    .id_instr(id_instr), .id_valid(id_valid), .fetch_cnt(fetch_cnt),
    .bubble_cnt(bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({PC, id_pc, id_instr, id_valid, fetch_cnt, bubble_cnt} !==
        {30'h0C00, 30'h0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_state: PC=%h id_pc=%h id_instr=%h id_valid=%b fc=%0d bc=%0d required PC=0c00 rest 0",
               PC, id_pc, id_instr, id_valid, fetch_cnt, bubble_cnt);
    end
    rst = 1'b0;
    checks++;
    if (imem_req !== 1'b1) begin
      fails++;
      $display("FAIL reset_req: imem_req=%b required 1", imem_req);
    end
  endtask

  task automatic test_sequential();
    logic [31:2] e;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(30'h0C00 + 30'(i));
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, e, instr_of(e)}) begin
        fails++;
        $display("FAIL seq_fetch: valid=%b id_pc=%h instr=%h required pc %h instr %h",
                 id_valid, id_pc, id_instr, e, instr_of(e));
      end
    end
  endtask

  task automatic test_wait();
    logic [31:2] e;
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({imem_addr, id_valid, id_instr} !== {30'h0C05, 1'b0, 32'h0}) begin
        fails++;
        $display("FAIL wait_bubble: addr=%h valid=%b instr=%h required addr 0c05 bubble",
                 imem_addr, id_valid, id_instr);
      end
    end
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(30'h0C05 + 30'(i));
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, e, instr_of(e)}) begin
        fails++;
        $display("FAIL wait_fetch: valid=%b id_pc=%h instr=%h required pc %h",
                 id_valid, id_pc, id_instr, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:2] e;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({id_valid, id_pc, id_instr, imem_req, PC} !==
          {1'b1, 30'h0C07, instr_of(30'h0C07), 1'b0, 30'h0C08}) begin
        fails++;
        $display("FAIL stall_hold: valid=%b id_pc=%h req=%b PC=%h required frozen 0c07, req 0, PC 0c08",
                 id_valid, id_pc, imem_req, PC);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(30'h0C08 + 30'(i));
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, e, instr_of(e)}) begin
        fails++;
        $display("FAIL stall_release: valid=%b id_pc=%h instr=%h required pc %h instr %h",
                 id_valid, id_pc, id_instr, e, instr_of(e));
      end
    end
  endtask

  task automatic test_flush_accept();
    logic [31:2] e;
    flush = 1'b1; npc_ovr = 30'h0D00; npc_ovr_en = 1'b1;
    tick();
    checks++;
    if ({id_valid, id_instr, id_pc, PC} !== {1'b0, 32'h0, 30'h0C09, 30'h0D00}) begin
      fails++;
      $display("FAIL flush_bubble: valid=%b instr=%h id_pc=%h PC=%h required bubble, id_pc 0c09, PC 0d00",
               id_valid, id_instr, id_pc, PC);
    end
    flush = 1'b0; npc_ovr_en = 1'b0;
    exp_q.push_back(30'h0D00);
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, e, instr_of(e)}) begin
      fails++;
      $display("FAIL flush_target: valid=%b id_pc=%h required pc %h", id_valid, id_pc, e);
    end
  endtask

  task automatic test_flush_pending();
    logic [31:2] e;
    flush = 1'b1; npc_ovr = 30'h0C10; npc_ovr_en = 1'b1;
    tick();
    flush = 1'b0; npc_ovr_en = 1'b0; imem_ready = 1'b0;
    tick();
    flush = 1'b1; npc_ovr = 30'h0E00; npc_ovr_en = 1'b1;
    tick();
    checks++;
    if ({imem_addr, id_valid} !== {30'h0C10, 1'b0}) begin
      fails++;
      $display("FAIL pend_flush: addr=%h valid=%b required addr 0c10 bubble", imem_addr, id_valid);
    end
    flush = 1'b0; npc_ovr_en = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 30'h0C10) begin
      fails++;
      $display("FAIL pend_addr_stable: addr=%h required 0c10", imem_addr);
    end
    imem_ready = 1'b1;
    tick();
    checks++;
    if ({imem_addr, id_valid} !== {30'h0E00, 1'b0}) begin
      fails++;
      $display("FAIL pend_drop: addr=%h valid=%b required addr 0e00 and 0c10 dropped", imem_addr, id_valid);
    end
    exp_q.push_back(30'h0E00);
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, e, instr_of(e)}) begin
      fails++;
      $display("FAIL pend_target: valid=%b id_pc=%h required pc %h", id_valid, id_pc, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:2] exp_next = 30'h0E01;
    logic [31:2] prev     = 30'h0E00;
    logic [31:2] addr_before;
    logic        waiting;
    logic [31:2] e;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        imem_ready = ($urandom_range(0, 3) != 0);
        stall      = ($urandom_range(0, 3) == 0);
      end else begin
        imem_ready = 1'b0;
        stall      = 1'b0;
      end
      #1;
      if (imem_req && imem_ready) begin
        exp_q.push_back(exp_next);
        exp_next = exp_next + 30'd1;
      end
      waiting     = imem_req && !imem_ready;
      addr_before = imem_addr;
      tick();
      if (waiting) begin
        checks++;
        if (imem_addr !== addr_before) begin
          fails++;
          $display("FAIL b2b_addr_hold: addr=%h required %h", imem_addr, addr_before);
        end
      end
      if (id_valid && id_pc !== prev) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 30'h3FFF_FFFF;
        checks++;
        if ({id_pc, id_instr} !== {e, instr_of(e)}) begin
          fails++;
          $display("FAIL b2b_fetch: id_pc=%h instr=%h required pc %h instr %h",
                   id_pc, id_instr, e, instr_of(e));
        end
        prev = id_pc;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_lost: %0d instructions undelivered, required 0", exp_q.size());
    end
    exp_q.delete();
    imem_ready = 1'b1;
  endtask

  task automatic test_perf_counters();
    logic [31:0] exp_f, exp_b;
`ifdef IF_PERF_CNT_EN
    exp_f = 32'd10; exp_b = 32'd4;
`else
    exp_f = 32'd0;  exp_b = 32'd0;
`endif
    @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    stall = 1'b0; flush = 1'b0; imem_ready = 1'b1; npc_ovr_en = 1'b0;
    repeat (10) tick();
    imem_ready = 1'b0;
    repeat (3) tick();
    imem_ready = 1'b1; flush = 1'b1; npc_ovr = 30'h0F00; npc_ovr_en = 1'b1;
    tick();
    flush = 1'b0; npc_ovr_en = 1'b0;
    checks++;
    if ({fetch_cnt, bubble_cnt, PC} !== {exp_f, exp_b, 30'h0F00}) begin
      fails++;
      $display("FAIL perf_counts: fetch=%0d bubble=%0d PC=%h required %0d %0d 0f00",
               fetch_cnt, bubble_cnt, PC, exp_f, exp_b);
    end
    tick();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({fetch_cnt, bubble_cnt, PC, id_valid, id_pc, imem_req} !==
        {32'h0, 32'h0, 30'h0C00, 1'b0, 30'h0, 1'b1}) begin
      fails++;
      $display("FAIL perf_async_rst: fetch=%0d bubble=%0d PC=%h valid=%b id_pc=%h req=%b required all cleared",
               fetch_cnt, bubble_cnt, PC, id_valid, id_pc, imem_req);
    end
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait();
    test_stall();
    test_flush_accept();
    test_flush_pending();
    test_back_to_back();
    test_perf_counters();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
